// File: rtl/r_alu_pkg.sv
// Shared types for the R-type ALU and its arbitrated wrapper.
// Op code is {idata[30],idata[25],idata[14:12]}.
package r_alu_pkg;

  localparam int XLEN_D  = 32;
  localparam int NREQ_D  = 2;
  localparam int TAG_W_D = 4;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000,
    OP_SUB  = 5'b10000,
    OP_SLL  = 5'b00001,
    OP_SLT  = 5'b00010,
    OP_SLTU = 5'b00011,
    OP_XOR  = 5'b00100,
    OP_SRL  = 5'b00101,
    OP_SRA  = 5'b10101,
    OP_OR   = 5'b00110,
    OP_AND  = 5'b00111
  } r_op_t;

  function automatic logic op_legal(
    input logic [4:0] op
  );
    logic ok;
    ok = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_SLL,
      OP_SLT, OP_SLTU, OP_XOR,
      OP_SRL, OP_SRA, OP_OR,
      OP_AND: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/r_alu_arbiter_if.sv
// Request/response bundle between requesters and the shared ALU.
// master = requester/consumer side, slave = arbiter side.
interface r_alu_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int NREQ  = 2,
  parameter int TAG_W = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0][4:0]       req_op;
  logic [NREQ-1:0][XLEN-1:0]  req_rv1;
  logic [NREQ-1:0][XLEN-1:0]  req_rv2;
  logic [NREQ-1:0][TAG_W-1:0] req_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic [TAG_W-1:0] rsp_tag;
  logic [XLEN-1:0]  rsp_data;
  logic             rsp_err;

  modport master (
    output req_valid, req_op,
    output req_rv1, req_rv2, req_tag,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid, rsp_id, rsp_tag,
    input  rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op,
    input  req_rv1, req_rv2, req_tag,
    input  rsp_ready,
    output req_ready,
    output rsp_valid, rsp_id, rsp_tag,
    output rsp_data, rsp_err
  );

endinterface

// File: rtl/r_alu.sv
// Combinational RV32I R-type ALU.
// Illegal op codes yield zero data with err set.
module r_alu
  import r_alu_pkg::*;
#(
  parameter int XLEN = XLEN_D
) (
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] rv1,
  input  logic [XLEN-1:0] rv2,
  output logic [XLEN-1:0] data,
  output logic            err
);

  logic [4:0] sh;
  logic       lt_s;
  logic       lt_u;

  assign sh   = rv2[4:0];
  assign lt_s = $signed(rv1) < $signed(rv2);
  assign lt_u = rv1 < rv2;

  always_comb begin
    data = '0;
    err  = !op_legal(op);
    case (op)
      OP_ADD:  data = rv1 + rv2;
      OP_SUB:  data = rv1 - rv2;
      OP_SLL:  data = rv1 << sh;
      OP_SLT:  data = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU: data = {{(XLEN-1){1'b0}}, lt_u};
      OP_XOR:  data = rv1 ^ rv2;
      OP_SRL:  data = rv1 >> sh;
      OP_SRA:  data = $unsigned($signed(rv1) >>> sh);
      OP_OR:   data = rv1 | rv2;
      OP_AND:  data = rv1 & rv2;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/r_alu_arbiter.sv
// Round-robin shared R-type ALU, two-stage pipeline
// (operand reg -> result reg), tagged single response channel.
module r_alu_arbiter
  import r_alu_pkg::*;
#(
  parameter int XLEN  = XLEN_D,
  parameter int NREQ  = NREQ_D,
  parameter int TAG_W = TAG_W_D
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  output logic busy,
  r_alu_arbiter_if.slave bus
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef struct packed {
    logic             valid;
    logic [4:0]       op;
    logic [XLEN-1:0]  rv1;
    logic [XLEN-1:0]  rv2;
    logic [TAG_W-1:0] tag;
    logic [IDW-1:0]   id;
  } a_t;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  data;
    logic             err;
    logic [TAG_W-1:0] tag;
    logic [IDW-1:0]   id;
  } b_t;

  a_t sa;
  b_t sb;

  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  gid;
  logic [IDW-1:0]  idx;
  logic            found;
  logic            live;
  logic            adv_a;
  logic            adv_b;
  logic            accept;
  logic [XLEN-1:0] alu_data;
  logic            alu_err;

  always_comb begin
    found = 1'b0;
    gid   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        gid   = idx;
      end
    end
  end

  assign adv_b  = !sb.valid | bus.rsp_ready;
  assign adv_a  = !sa.valid | adv_b;
  // live keeps req_ready low for the whole reset window
  assign accept = found & adv_a & !flush & live;

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[gid] = 1'b1;
  end

  r_alu #(.XLEN(XLEN)) u_alu (
    .op   (sa.op),
    .rv1  (sa.rv1),
    .rv2  (sa.rv2),
    .data (alu_data),
    .err  (alu_err)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live <= 1'b0;
      ptr  <= '0;
    end else begin
      live <= 1'b1;
      if (accept)
        ptr <= (gid == IDW'(NREQ - 1)) ?
               '0 : gid + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sa <= '0;
    end else if (flush) begin
      sa.valid <= 1'b0;
    end else if (adv_a) begin
      sa.valid <= accept;
      if (accept) begin
        sa.op  <= bus.req_op[gid];
        sa.rv1 <= bus.req_rv1[gid];
        sa.rv2 <= bus.req_rv2[gid];
        sa.tag <= bus.req_tag[gid];
        sa.id  <= gid;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb <= '0;
    end else if (flush) begin
      sb.valid <= 1'b0;
    end else if (adv_b) begin
      sb.valid <= sa.valid;
      if (sa.valid) begin
        sb.data <= alu_data;
        sb.err  <= alu_err;
        sb.tag  <= sa.tag;
        sb.id   <= sa.id;
      end
    end
  end

  assign bus.rsp_valid = sb.valid;
  assign bus.rsp_id    = sb.id;
  assign bus.rsp_tag   = sb.tag;
  assign bus.rsp_data  = sb.data;
  assign bus.rsp_err   = sb.err;
  assign busy          = sa.valid | sb.valid;

endmodule
